// File: rtl/queue_serializer_if.sv
// queue_serializer_if: queue dequeue port plus serial bit handshake
// slave modport is the serializer side, master is the queue/sink side
interface queue_serializer_if;
  logic [3:0] len_in;
  logic [7:0] data_in;
  logic       deq_out;
  logic       ready_in;
  logic       data_out;
  logic       valid_out;
  logic       last_out;
  logic       busy_out;
  logic [7:0] count_out;

  modport slave (
    input  len_in,
    input  data_in,
    input  ready_in,
    output deq_out,
    output data_out,
    output valid_out,
    output last_out,
    output busy_out,
    output count_out
  );

  modport master (
    output len_in,
    output data_in,
    output ready_in,
    input  deq_out,
    input  data_out,
    input  valid_out,
    input  last_out,
    input  busy_out,
    input  count_out
  );
endinterface

// File: rtl/queue_serializer.sv
// queue_serializer: pops bytes from the queue, shifts them out MSB-first
// QUEUE_SERIALIZER_PARITY_EN appends an even-parity bit (9-bit frames)
module queue_serializer (
  input logic               clock_10,
  input logic               reset,
  queue_serializer_if.slave bus
);

`ifdef QUEUE_SERIALIZER_PARITY_EN
  localparam logic [3:0] LP_LAST = 4'd8;
`else
  localparam logic [3:0] LP_LAST = 4'd7;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEQ   = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_shreg;
  logic       r_par;
  logic [3:0] r_bitcnt;
  logic [7:0] r_count;
  logic       w_xfer;
  logic       w_final;
  logic       w_pend;
  logic       w_par;

  assign w_pend  = |bus.len_in;
  assign w_xfer  = (r_state == SHIFT) & bus.ready_in;
  assign w_final = w_xfer & (r_bitcnt == LP_LAST);

`ifdef QUEUE_SERIALIZER_PARITY_EN
  assign w_par = ^bus.data_in;
`else
  assign w_par = 1'b0;
`endif

  // state register
  always_ff @(posedge clock_10 or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_pend) w_next = DEQ;
      DEQ:   w_next = LOAD;
      LOAD:  w_next = SHIFT;
      SHIFT: if (w_final) w_next = w_pend ? DEQ : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // shift register, bit counter, frame counter
  always_ff @(posedge clock_10 or posedge reset) begin
    if (reset) begin
      r_shreg  <= 8'd0;
      r_par    <= 1'b0;
      r_bitcnt <= 4'd0;
      r_count  <= 8'd0;
    end else begin
      if (r_state == LOAD) begin
        r_shreg  <= bus.data_in;
        r_par    <= w_par;
        r_bitcnt <= 4'd0;
      end else if (w_xfer) begin
        // parity bit trails the data bits into shreg[7]
        r_shreg  <= {r_shreg[6:0], r_par};
        r_bitcnt <= r_bitcnt + 4'd1;
      end
      if (w_final) r_count <= r_count + 8'd1;
    end
  end

  assign bus.deq_out   = (r_state == DEQ);
  assign bus.valid_out = (r_state == SHIFT);
  assign bus.data_out  = (r_state == SHIFT) & r_shreg[7];
  assign bus.last_out  = (r_state == SHIFT) & (r_bitcnt == LP_LAST);
  assign bus.busy_out  = (r_state != IDLE);
  assign bus.count_out = r_count;

endmodule

// File: tb/tb_queue_serializer.sv
// tb_queue_serializer: directed tests for queue_serializer
// queue modelled inline; pops on the edge ending DEQ
module tb_queue_serializer;

`ifdef QUEUE_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clock_10 = 1'b0;
  logic reset;
  queue_serializer_if bus ();

  queue_serializer dut (
    .clock_10 (clock_10),
    .reset    (reset),
    .bus      (bus)
  );

  always #50 clock_10 = ~clock_10;

  int total = 0;
  int bad = 0;
  logic [7:0] qmem [0:7];
  int qhead;
  int qcnt;
  int deq_pulses;
  logic [31:0] cap;
  logic [31:0] lastv;
  int ncap;
  int gaps;
  int holdbad;

  task automatic tick();
    logic dq;
    @(negedge clock_10);
    dq = bus.deq_out;
    @(posedge clock_10);
    #1;
    if (dq && !reset) begin
      deq_pulses++;
      if (qcnt > 0) begin
        bus.data_in = qmem[qhead];
        qhead++;
        qcnt--;
      end
      bus.len_in = 4'(qcnt);
    end
  endtask

  task automatic load_q(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int n);
    qmem[0] = b0;
    qmem[1] = b1;
    qmem[2] = b2;
    qhead = 0;
    qcnt = n;
    bus.len_in = 4'(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ready_in = 1'b0;
    tick();
    tick();
    qcnt = 0;
    qhead = 0;
    bus.len_in = 4'd0;
    bus.data_in = 8'd0;
    deq_pulses = 0;
    reset = 1'b0;
  endtask

  task automatic capture(input int nbits, input logic [15:0] pat,
                         input int maxcyc);
    logic hold_on = 1'b0;
    logic hold_v = 1'b0;
    logic started = 1'b0;
    ncap = 0;
    cap = '0;
    lastv = '0;
    gaps = 0;
    holdbad = 0;
    for (int c = 0; c < maxcyc; c++) begin
      bus.ready_in = pat[c % 16];
      if (hold_on && bus.valid_out && bus.data_out !== hold_v)
        holdbad++;
      hold_on = 1'b0;
      if (bus.valid_out) begin
        started = 1'b1;
        if (bus.ready_in) begin
          cap = {cap[30:0], bus.data_out};
          lastv = {lastv[30:0], bus.last_out};
          ncap++;
        end else begin
          hold_on = 1'b1;
          hold_v = bus.data_out;
        end
      end else if (started) begin
        gaps++;
      end
      tick();
      if (ncap == nbits) break;
    end
    bus.ready_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] o;
    reset = 1'b1;
    bus.ready_in = 1'b0;
    bus.data_in = 8'd0;
    deq_pulses = 0;
    load_q(8'h12, 8'h34, 8'h56, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      o = {bus.deq_out, bus.data_out, bus.valid_out, bus.last_out,
           bus.busy_out, bus.count_out};
      total++;
      if (o !== 13'd0) begin
        bad++;
        $display("FAIL reset_outs got=%h want=0", o);
      end
    end
    total++;
    if (deq_pulses !== 0) begin
      bad++;
      $display("FAIL reset_nodeq got=%0d want=0", deq_pulses);
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.deq_out !== 1'b1) begin
      bad++;
      $display("FAIL rel_deq_hi got=%b want=1", bus.deq_out);
    end
    tick();
    total++;
    if (bus.deq_out !== 1'b0) begin
      bad++;
      $display("FAIL rel_deq_lo got=%b want=0", bus.deq_out);
    end
    total++;
    if (deq_pulses !== 1) begin
      bad++;
      $display("FAIL rel_pulses got=%0d want=1", deq_pulses);
    end
  endtask

  task automatic test_single();
    logic [8:0] exp_b;
    logic [8:0] exp_l;
`ifdef QUEUE_SERIALIZER_PARITY_EN
    exp_b = 9'b1010_0101_0;
    exp_l = 9'b0000_0000_1;
`else
    exp_b = 9'h0A5;
    exp_l = 9'h001;
`endif
    do_reset();
    load_q(8'hA5, 8'h00, 8'h00, 1);
    tick();
    total++;
    if (bus.deq_out !== 1'b1) begin
      bad++;
      $display("FAIL lat_deq got=%b want=1", bus.deq_out);
    end
    tick();
    total++;
    if ({bus.deq_out, bus.valid_out} !== 2'b00) begin
      bad++;
      $display("FAIL lat_load got=%b%b want=00", bus.deq_out,
               bus.valid_out);
    end
    tick();
    total++;
    if (bus.valid_out !== 1'b1) begin
      bad++;
      $display("FAIL lat_valid got=%b want=1", bus.valid_out);
    end
    capture(NB, 16'hFFFF, 40);
    total++;
    if (ncap !== NB || cap[8:0] !== exp_b) begin
      bad++;
      $display("FAIL single_bits got=%0d/%b want=%0d/%b", ncap, cap[8:0],
               NB, exp_b);
    end
    total++;
    if (lastv[8:0] !== exp_l) begin
      bad++;
      $display("FAIL single_last got=%b want=%b", lastv[8:0], exp_l);
    end
    total++;
    if (bus.count_out !== 8'd1 || bus.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL single_end got=%0d/%b want=1/0", bus.count_out,
               bus.busy_out);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp_b;
`ifdef QUEUE_SERIALIZER_PARITY_EN
    exp_b = 9'b0011_1100_0;
`else
    exp_b = 9'h03C;
`endif
    do_reset();
    load_q(8'h3C, 8'h00, 8'h00, 1);
    capture(NB, 16'h9999, 80);
    total++;
    if (ncap !== NB || cap[8:0] !== exp_b) begin
      bad++;
      $display("FAIL bp_bits got=%0d/%b want=%0d/%b", ncap, cap[8:0],
               NB, exp_b);
    end
    total++;
    if (holdbad !== 0) begin
      bad++;
      $display("FAIL bp_hold got=%0d want=0", holdbad);
    end
    total++;
    if (bus.count_out !== 8'd1) begin
      bad++;
      $display("FAIL bp_count got=%0d want=1", bus.count_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] exp_b;
    logic [26:0] exp_l;
`ifdef QUEUE_SERIALIZER_PARITY_EN
    exp_b = 27'b000000011_100000001_111111110;
    exp_l = 27'b000000001_000000001_000000001;
`else
    exp_b = 27'h00180FF;
    exp_l = 27'h0010101;
`endif
    do_reset();
    load_q(8'h01, 8'h80, 8'hFF, 3);
    capture(3 * NB, 16'hFFFF, 120);
    total++;
    if (ncap !== 3 * NB || cap[26:0] !== exp_b) begin
      bad++;
      $display("FAIL b2b_bits got=%0d/%h want=%0d/%h", ncap, cap[26:0],
               3 * NB, exp_b);
    end
    total++;
    if (lastv[26:0] !== exp_l) begin
      bad++;
      $display("FAIL b2b_last got=%h want=%h", lastv[26:0], exp_l);
    end
    total++;
    if (gaps !== 4) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want=4", gaps);
    end
    total++;
    if (deq_pulses !== 3) begin
      bad++;
      $display("FAIL b2b_deq got=%0d want=3", deq_pulses);
    end
    total++;
    if (bus.count_out !== 8'd3 || bus.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%0d/%b want=3/0", bus.count_out,
               bus.busy_out);
    end
  endtask

  task automatic test_empty();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      tick();
      total++;
      if ({bus.deq_out, bus.valid_out, bus.busy_out} !== 3'b000) begin
        bad++;
        $display("FAIL empty_idle cyc=%0d got=%b%b%b want=000", i,
                 bus.deq_out, bus.valid_out, bus.busy_out);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [12:0] o;
    logic [8:0] exp_b;
`ifdef QUEUE_SERIALIZER_PARITY_EN
    exp_b = 9'b0101_1010_0;
`else
    exp_b = 9'h05A;
`endif
    do_reset();
    load_q(8'h11, 8'hF0, 8'h5A, 3);
    capture(NB, 16'hFFFF, 40);
    total++;
    if (bus.count_out !== 8'd1) begin
      bad++;
      $display("FAIL mid_pre_count got=%0d want=1", bus.count_out);
    end
    capture(4, 16'hFFFF, 40);
    total++;
    if (ncap !== 4 || cap[3:0] !== 4'hF) begin
      bad++;
      $display("FAIL mid_part got=%0d/%b want=4/1111", ncap, cap[3:0]);
    end
    #20;
    reset = 1'b1;
    #1;
    o = {bus.deq_out, bus.data_out, bus.valid_out, bus.last_out,
         bus.busy_out, bus.count_out};
    total++;
    if (o !== 13'd0) begin
      bad++;
      $display("FAIL mid_async got=%h want=0", o);
    end
    tick();
    tick();
    reset = 1'b0;
    capture(NB, 16'hFFFF, 40);
    total++;
    if (ncap !== NB || cap[8:0] !== exp_b) begin
      bad++;
      $display("FAIL mid_next got=%0d/%b want=%0d/%b", ncap, cap[8:0],
               NB, exp_b);
    end
    total++;
    if (deq_pulses !== 3 || bus.count_out !== 8'd1) begin
      bad++;
      $display("FAIL mid_end got=%0d/%0d want=3/1", deq_pulses,
               bus.count_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.ready_in = 1'b0;
    bus.len_in = 4'd0;
    bus.data_in = 8'd0;
    qhead = 0;
    qcnt = 0;
    deq_pulses = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_empty();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/queue_serializer.md
# queue_serializer

Transmit-side drain for the byte queue: pops bytes from the 8-entry queue when it is non-empty and shifts each byte out MSB-first as a serial bitstream under a valid/ready handshake. It sits downstream of the queue's dequeue port and is the counterpart of the deserializer that fills the queue. Runs entirely in the 10 kHz clock domain.

## Interface
- No parameters; byte width fixed at 8, queue depth fixed at 8.
- clock_10  in  1  system clock, 10 kHz, rising-edge.
- reset  in  1  asynchronous, active-high.
- len_in  in  4  queue occupancy, from queue len_out (0..8).
- data_in  in  8  dequeued byte, from queue data_out.
- deq_out  out  1  dequeue request to queue deq_in; one-cycle pulse.
- ready_in  in  1  downstream accepts the current bit.
- data_out  out  1  serial bit, valid while valid_out=1.
- valid_out  out  1  data_out holds a bit awaiting transfer.
- last_out  out  1  high with the final bit of the current frame.
- busy_out  out  1  high in any state except IDLE.
- count_out  out  8  frames completed since reset, wraps 255->0.

## Operation
- FSM states: IDLE, DEQ, LOAD, SHIFT.
- IDLE: if len_in != 0 -> DEQ; else stay.
- DEQ: deq_out=1 for exactly this cycle; -> LOAD. Queue pops and updates data_in/len_in on the edge ending DEQ.
- LOAD: shreg <= data_in on the edge ending LOAD; bitcnt <= 0; -> SHIFT.
- SHIFT: valid_out=1, data_out=shreg[7]. Transfer occurs on a rising edge with valid_out & ready_in: shreg shifts left by 1, bitcnt increments. ready_in low holds data_out/bitcnt stable indefinitely.
- last_out=1 in SHIFT when bitcnt = N-1 (N = frame length, 8 or 9).
- On the final transfer: count_out <= count_out+1; -> DEQ if len_in != 0, else IDLE.
- Never asserts deq_out when len_in = 0; never asserts deq_out outside DEQ, so at most one pop per frame.
- bitcnt is 4 bits; count_out arithmetic is modulo 256.

## Timing
- Reset values: deq_out=0, data_out=0, valid_out=0, last_out=0, busy_out=0, count_out=0; state=IDLE, shreg=0, bitcnt=0.
- All outputs are registered or decoded from registered state only; no combinational path from ready_in or len_in to any output.
- Latency: len_in becomes non-zero at edge E -> deq_out high in cycle after E -> first valid_out two cycles later (IDLE, DEQ, LOAD, SHIFT).
- Back-to-back frames: final transfer edge -> DEQ -> LOAD -> SHIFT; gap of 2 cycles with valid_out=0.
- With ready_in held high, one frame takes N cycles in SHIFT.
- Queue empties mid-frame: no effect on current frame; FSM returns to IDLE after it.
- Reset asserted mid-frame: immediate return to reset values; the already-popped byte is discarded, not re-queued.
- ready_in high while valid_out=0: ignored.

## Configuration
- QUEUE_SERIALIZER_PARITY_EN defined: frame is 9 bits; the 8 data bits followed by an even-parity bit (XOR of the 8 data bits, latched in LOAD); last_out marks the parity bit.
- Undefined: frame is 8 data bits; last_out marks bit 0 of the byte.

## Test plan
- Reset: hold reset with len_in=3 -> all outputs 0, no deq_out; release -> deq_out pulse exactly one cycle in the following cycle.
- Single byte 0xA5, ready_in=1: data_out sequence 1,0,1,0,0,1,0,1, last_out on 8th bit, count_out 0->1, back to IDLE (parity build: 9th bit 0).
- Backpressure: byte 0x3C, ready_in toggling 1,0,0,1,...: each bit held while ready_in=0, no bit skipped or duplicated, same sequence 0,0,1,1,1,1,0,0.
- Back-to-back: queue holds 0x01,0x80,0xFF (len_in=3): exactly three deq_out pulses, 2-cycle valid_out gap between frames, count_out=3, parity bits 1,1,0 when enabled.
- Empty queue: len_in=0 for 50 cycles -> deq_out, valid_out, busy_out stay 0.
- Reset mid-frame after 4 bits of 0xF0: outputs return to reset values asynchronously, count_out=0; next frame after release starts from a fresh dequeue.
